// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-requester MMIO bus arbiter.
package mmio_arb_pkg;

   // Arbiter transaction phases.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Requester identity: 0 is the core load/store unit, 1 is the DMA engine.
   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   // Converts a one-hot two-way grant into the requester that owns it.
   function automatic req_id_t grant_to_id(input logic [1:0] grant);
      return grant[1] ? REQ1 : REQ0;
   endfunction

endpackage

// File: rtl/mmio_rr_arbiter.sv
// Two-way round-robin grant: whoever was not granted last wins a tie.
module mmio_rr_arbiter
   import mmio_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] request,
   input  logic       enable,
   output logic [1:0] grant
);

   req_id_t last_grant;

   // Pick one requester when grants are allowed; a tie goes to the one not served last.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (request == 2'b11) begin
            grant = (last_grant == REQ0) ? 2'b10 : 2'b01;
         end else begin
            grant = request;
         end
      end
   end

   // Remember who was granted; resetting to REQ1 hands the first tie to req0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= REQ1;
      end else if (|grant) begin
         last_grant <= grant_to_id(grant);
      end
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO data bus between the core LSU (req0) and the DMA (req1),
// one transaction at a time, with a bounded wait for the slave's ack.
module mmio_bus_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req0_read,
   input  logic [31:0] req0_address,
   input  logic [31:0] req0_store,
   output logic        req0_ready,
   output logic        req0_rvalid,
   output logic [31:0] req0_rdata,
   output logic        req0_err,
   input  logic        req1_valid,
   input  logic        req1_read,
   input  logic [31:0] req1_address,
   input  logic [31:0] req1_store,
   output logic        req1_ready,
   output logic        req1_rvalid,
   output logic [31:0] req1_rdata,
   output logic        req1_err,
   output logic [31:0] data_address,
   output logic [31:0] data_store,
   output logic        data_read,
   output logic        data_enable,
   input  logic [31:0] data_fetch,
   input  logic        bus_ack
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t  state;
   arb_state_t  next_state;
   req_id_t     owner;
   logic [31:0] address_q;
   logic [31:0] store_q;
   logic        read_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [7:0]  wait_count;
   logic [1:0]  grant;

   mmio_rr_arbiter u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .request ({req1_valid, req0_valid}),
      .enable  (state == IDLE),
      .grant   (grant)
   );

   // State register; reset drops any in-flight transaction on the floor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; bus_ack only matters while the bus is driven.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|grant) next_state = ISSUE;
         ISSUE:   next_state = bus_ack ? RESP : WAIT;
         WAIT:    if (bus_ack || (wait_count == LAST_WAIT)) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latches, wait counter and completion capture; ack beats timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= REQ0;
         address_q  <= '0;
         store_q    <= '0;
         read_q     <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         wait_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner     <= grant_to_id(grant);
                  address_q <= grant[1] ? req1_address : req0_address;
                  store_q   <= grant[1] ? req1_store   : req0_store;
                  read_q    <= grant[1] ? req1_read    : req0_read;
               end
            end
            ISSUE: begin
               wait_count <= '0;
               if (bus_ack) begin
                  rdata_q <= read_q ? data_fetch : '0;
                  err_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (bus_ack) begin
                  rdata_q <= read_q ? data_fetch : '0;
                  err_q   <= 1'b0;
               end else begin
                  wait_count <= wait_count + 8'd1;
                  if (wait_count == LAST_WAIT) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs: ready only in IDLE, bus only in ISSUE/WAIT, completion only in RESP.
   always_comb begin
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      req0_rvalid  = 1'b0;
      req1_rvalid  = 1'b0;
      req0_rdata   = '0;
      req1_rdata   = '0;
      req0_err     = 1'b0;
      req1_err     = 1'b0;
      data_address = '0;
      data_store   = '0;
      data_read    = 1'b0;
      data_enable  = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
         end
         ISSUE, WAIT: begin
            data_enable  = 1'b1;
            data_address = address_q;
            data_store   = store_q;
            data_read    = read_q;
         end
         RESP: begin
            if (owner == REQ0) begin
               req0_rvalid = 1'b1;
               req0_rdata  = rdata_q;
               req0_err    = err_q;
            end else begin
               req1_rvalid = 1'b1;
               req1_rdata  = rdata_q;
               req1_err    = err_q;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/mmio_bus_arbiter.md
MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the max WAIT cycles before an error completion (legal 1..255).
REQ-002 SHALL have ports: clk, input, 1, sole clock, all state on posedge.
REQ-003 SHALL have ports: rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports: reqN_valid, input, 1 each (N=0 core LSU, N=1 DMA), request present.
REQ-005 SHALL have ports: reqN_read, input, 1 each, 1=load, 0=store.
REQ-006 SHALL have ports: reqN_address and reqN_store, input, 32 each, address and store data.
REQ-007 SHALL have ports: reqN_ready, output, 1 each, request accepted this cycle.
REQ-008 SHALL have ports: reqN_rvalid, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have ports: reqN_rdata, output, 32 each, load data; reqN_err, output, 1 each, timeout flag.
REQ-010 SHALL have ports: data_address and data_store, output, 32 each, shared bus to the MMIO decoder.
REQ-011 SHALL have ports: data_read and data_enable, output, 1 each, bus qualifiers.
REQ-012 SHALL have ports: data_fetch, input, 32, slave read data; bus_ack, input, 1, slave completion.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 SHALL, in IDLE with any reqN_valid, grant one requester, assert its reqN_ready that cycle, latch its address/store/read, and go to ISSUE.
REQ-015 SHALL resolve simultaneous valids round-robin: the requester not granted last wins; priority after reset is req0.
REQ-016 SHALL never assert both reqN_ready in one cycle, and SHALL never assert reqN_ready outside IDLE.
REQ-017 SHALL drive data_enable=1 with latched address/store/read throughout ISSUE and WAIT, and SHALL drive data_enable=0 with all bus outputs 0 otherwise.
REQ-018 SHALL transition ISSUE->RESP if bus_ack=1, else ISSUE->WAIT; in ISSUE it SHALL clear the 8-bit wait counter.
REQ-019 SHALL, in WAIT, increment the counter each cycle bus_ack=0, and go to RESP when bus_ack=1 or when the counter equals TIMEOUT_CYCLES-1.
REQ-020 SHALL, if bus_ack and timeout coincide, give ack priority (err=0).
REQ-021 SHALL capture data_fetch on the ack cycle for loads; on timeout it SHALL set rdata=0 and err=1; for stores it SHALL set rdata=0.
REQ-022 SHALL, in RESP, pulse reqN_rvalid for exactly one cycle for the granted N only, hold rdata/err valid that cycle, then return to IDLE.
REQ-023 SHALL give minimum latency of 3 cycles: accept (IDLE) -> ISSUE -> rvalid (RESP).
REQ-024 SHALL ignore bus_ack in IDLE and RESP.
REQ-025 SHALL treat a reqN_valid deasserted before ready as never issued.
REQ-026 SHALL not require the requester to hold fields after the accept cycle.

Reset
REQ-027 SHALL, on rst_n low, immediately enter IDLE, clear the counter and latches, set priority to req0, and drive all outputs 0.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, with no rvalid issued for it.

Structure
REQ-029 SHALL place the state enum, requester-ID typedef, and default timeout constant in package mmio_arb_pkg.
REQ-030 SHALL put the two-way round-robin grant logic (request vector in, one-hot grant out, priority flop) in sub-module mmio_rr_arbiter.

Verification
REQ-031 SHALL test: req0 load 0x00200404, bus_ack in ISSUE, data_fetch=0xDEADBEEF -> req0_ready at T0, data_enable T1, req0_rvalid T2 with rdata 0xDEADBEEF, err=0.
REQ-032 SHALL test: req0 and req1 valid every cycle from reset, instant ack -> grants alternate 0,1,0,1, with one rvalid per grant.
REQ-033 SHALL test: req1 store 0x00200800 data 0x12345678, no ack, TIMEOUT_CYCLES=4 -> data_enable held 5 cycles, then req1_rvalid with err=1 and rdata=0.
REQ-034 SHALL test: bus_ack arriving on the final timeout cycle -> err=0 and rdata=data_fetch.
REQ-035 SHALL test: rst_n asserted during WAIT -> outputs 0 at once, no rvalid, and the next request after release is granted to req0.
REQ-036 SHALL test: bus_ack pulses in IDLE with no valids -> no state change and all outputs remain 0.
